fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_pkg.sv | 14 +
 rtl/fetch_ctrl_if.sv | 31 +++
 rtl/fetch_ctrl_pc_incr.sv | 9 +
 rtl/fetch_ctrl.sv | 99 +++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        StFetch  = 2'd0,
        StDrain  = 2'd1,
        StIssue  = 2'd2,
        StHalted = 2'd3
    } fetch_state_e;

    localparam logic [15:0] RESET_PC  = 16'h0000;
    localparam logic [15:0] NOP_INSTR = 16'h0800;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch controller bus: decode-side handshake plus instruction-memory port.
interface fetch_ctrl_if;
    import fetch_ctrl_pkg::*;

    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_done;
    logic [15:0] instr;
    logic        instr_valid;
    logic [15:0] pc_plus2;
    logic        halted;
    logic        err;

    // Fetch controller side
    modport master (
        input  stall, redirect, redirect_pc, halt, mem_rdata, mem_done,
        output mem_req, mem_addr, instr, instr_valid, pc_plus2, halted, err
    );

    // Decode / memory side
    modport slave (
        output stall, redirect, redirect_pc, halt, mem_rdata, mem_done,
        input  mem_req, mem_addr, instr, instr_valid, pc_plus2, halted, err
    );

endinterface

// File: rtl/fetch_ctrl_pc_incr.sv
// 16-bit +2 incrementer; wraps 0xFFFE -> 0x0000.
module pc_incr (
    input  logic [15:0] pc_i,
    output logic [15:0] pc_plus2_o
);

    assign pc_plus2_o = pc_i + 16'd2;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: one outstanding memory request, registered
// instruction to decode, redirect with drain of an in-flight request, halt.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    fetch_ctrl_if.master   bus
);

    fetch_state_e state_q, state_d;
    logic [15:0]  fetch_addr_q, fetch_addr_d;
    logic [15:0]  pend_q, pend_d;
    logic [15:0]  instr_q, instr_d;
    logic [15:0]  pc_plus2_q, pc_plus2_d;
    logic [15:0]  fetch_addr_inc;

    pc_incr u_pc_incr (
        .pc_i       (fetch_addr_q),
        .pc_plus2_o (fetch_addr_inc)
    );

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StFetch;
            fetch_addr_q <= RESET_PC;
            pend_q       <= RESET_PC;
            instr_q      <= NOP_INSTR;
            pc_plus2_q   <= RESET_PC + 16'd2;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            pend_q       <= pend_d;
            instr_q      <= instr_d;
            pc_plus2_q   <= pc_plus2_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        pend_d       = pend_q;
        instr_d      = instr_q;
        pc_plus2_d   = pc_plus2_q;
        unique case (state_q)
            StFetch: begin
                if (bus.mem_done) begin
                    if (bus.redirect) begin
                        fetch_addr_d = bus.redirect_pc;
                    end else begin
                        instr_d      = bus.mem_rdata;
                        pc_plus2_d   = fetch_addr_inc;
                        fetch_addr_d = fetch_addr_inc;
                        state_d      = StIssue;
                    end
                end else if (bus.redirect) begin
                    pend_d  = bus.redirect_pc;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // Latest redirect wins, including one arriving with mem_done
                if (bus.redirect) begin
                    pend_d = bus.redirect_pc;
                end
                if (bus.mem_done) begin
                    fetch_addr_d = bus.redirect ? bus.redirect_pc : pend_q;
                    state_d      = StFetch;
                end
            end
            StIssue: begin
                if (bus.redirect) begin
                    fetch_addr_d = bus.redirect_pc;
                    state_d      = StFetch;
                end else if (!bus.stall && bus.halt) begin
                    state_d = StHalted;
                end else if (!bus.stall) begin
                    state_d = StFetch;
                end
            end
            StHalted: state_d = StHalted;
            default:  state_d = StFetch;
        endcase
    end

    // Outputs decoded from state; rst gates the request so it drops at once
    always_comb begin
        bus.mem_req     = ((state_q == StFetch) || (state_q == StDrain)) && !rst;
        bus.mem_addr    = fetch_addr_q;
        bus.instr       = instr_q;
        bus.instr_valid = (state_q == StIssue);
        bus.pc_plus2    = pc_plus2_q;
        bus.halted      = (state_q == StHalted);
        bus.err         = bus.mem_done && !bus.mem_req;
    end

endmodule
